// File: rtl/des_pkg.sv
// des_pkg: shared constants for the DES S-box pipeline -- the eight FIPS 46-3
// S-box tables, the P permutation and the legal LANES/DEPTH limits.
// The P permutation is only used when the top is built with DES_SBOX_PERM_EN.
package des_pkg;

   localparam int LANES_MIN = 1;
   localparam int LANES_MAX = 4;
   localparam int DEPTH_MIN = 1;
   localparam int DEPTH_MAX = 4;

   // Each S-box is 64 nibbles in row-major order (index row*16+col); entry 0
   // (row 0, column 0) sits in the most significant nibble.
   localparam logic [255:0] SBOX_TBL [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   // P table in FIPS numbering: output bit i (1 = MSB) takes input bit P_TBL[i-1].
   localparam int P_TBL [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
   };

   function automatic logic [31:0] des_perm(input logic [31:0] x);
      logic [31:0] y;
      logic [4:0]  src;
      y = '0;
      for (int i = 0; i < 32; i++) begin
         src = 5'(32 - P_TBL[i]);
         y[5'(31 - i)] = x[src];
      end
      return y;
   endfunction

endpackage

// File: rtl/des_sbox_pipe_if.sv
// des_sbox_pipe_if: valid/ready stream bundle around des_sbox_pipe.
// master = beat source and sink (bench / surrounding logic), slave = the pipeline.
interface des_sbox_pipe_if #(
   parameter int LANES = 1
);
   logic                  in_valid;
   logic                  in_ready;
   logic [48*LANES-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [32*LANES-1:0]   out_data;
   logic                  busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/des_sbox_lut.sv
// des_sbox_lut: one DES 6-to-4 substitution; BOX selects S1..S8.
// Row is {b5,b0}, column is b[4:1].
module des_sbox_lut
   import des_pkg::*;
#(
   parameter int BOX = 1
) (
   input  logic [5:0] i_grp,
   output logic [3:0] o_val
);

   if (BOX < 1 || BOX > 8) begin : g_bad_box
      $error("des_sbox_lut: BOX=%0d outside 1..8", BOX);
   end

   localparam int             TBL_IDX = (BOX >= 1 && BOX <= 8) ? BOX - 1 : 0;
   localparam logic [255:0]   TBL     = SBOX_TBL[TBL_IDX];

   logic [5:0] w_idx;
   logic [7:0] w_msb;

   // Entry idx lives at bit 255-4*idx, which is {~idx, 2'b11} for a 6-bit idx.
   assign w_idx = {i_grp[5], i_grp[0], i_grp[4:1]};
   assign w_msb = {~w_idx, 2'b11};
   assign o_val = TBL[w_msb -: 4];

endmodule

// File: rtl/des_sbox_pipe.sv
// des_sbox_pipe: LANES parallel DES S-box substitutions (48 -> 32 bits per lane)
// followed by a DEPTH-stage valid/ready pipeline with per-stage valid bits.
// Optional macro DES_SBOX_PERM_EN routes each lane through the DES P permutation
// ahead of stage 1; latency and handshake are the same in both builds.
module des_sbox_pipe
   import des_pkg::*;
#(
   parameter int LANES = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   des_sbox_pipe_if.slave   bus
);

   localparam int OUT_W = 32 * LANES;

   if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_bad_lanes
      $error("des_sbox_pipe: LANES=%0d outside %0d..%0d", LANES, LANES_MIN, LANES_MAX);
   end
   if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("des_sbox_pipe: DEPTH=%0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
   end

   logic [OUT_W-1:0] w_raw;
   logic [OUT_W-1:0] w_sub;
   logic [DEPTH-1:0] w_rdy;
   logic [DEPTH-1:0] w_vin;
   logic [OUT_W-1:0] w_din  [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [OUT_W-1:0] r_data [DEPTH];

   // Substitution is purely combinational and feeds stage 1 directly.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      for (genvar b = 0; b < 8; b++) begin : g_box
         des_sbox_lut #(.BOX(b + 1)) u_lut (
            .i_grp (bus.in_data[48*k + 47 - 6*b -: 6]),
            .o_val (w_raw[32*k + 31 - 4*b -: 4])
         );
      end
`ifdef DES_SBOX_PERM_EN
      assign w_sub[32*k +: 32] = des_perm(w_raw[32*k +: 32]);
`else
      assign w_sub[32*k +: 32] = w_raw[32*k +: 32];
`endif
   end

   // Stage 1 loads from the substitution, later stages from their predecessor.
   for (genvar gs = 0; gs < DEPTH; gs++) begin : g_feed
      if (gs == 0) begin : g_head
         assign w_vin[gs] = bus.in_valid;
         assign w_din[gs] = w_sub;
      end else begin : g_body
         assign w_vin[gs] = r_vld[gs-1];
         assign w_din[gs] = r_data[gs-1];
      end
   end

   // A stage can load when it or any later stage has a hole, or the sink drains.
   always_comb begin : p_ready
      logic w_full;
      w_full = 1'b1;
      w_rdy  = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
         w_full   = w_full & r_vld[s];
         w_rdy[s] = bus.out_ready | ~w_full;
      end
   end

   // Pipeline stages: valid follows every load, data only updates on a real beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < DEPTH; s++) begin
            r_vld[s]  <= 1'b0;
            r_data[s] <= '0;
         end
      end else begin
         for (int s = 0; s < DEPTH; s++) begin
            if (w_rdy[s]) begin
               r_vld[s] <= w_vin[s];
               if (w_vin[s]) begin
                  r_data[s] <= w_din[s];
               end
            end
         end
      end
   end

   assign bus.in_ready  = w_rdy[0];
   assign bus.out_valid = r_vld[DEPTH-1];
   assign bus.out_data  = r_data[DEPTH-1];
   assign bus.busy      = |r_vld;

endmodule

// File: tb/tb_des_sbox_pipe.sv
// tb_des_sbox_pipe: self-checking bench for des_sbox_pipe with LANES=4, DEPTH=2.
// Expected beats come from a table-driven model of the DES S-boxes (and P when
// DES_SBOX_PERM_EN is defined) held in a scoreboard queue.
module tb_des_sbox_pipe;

   localparam int LANES = 4;
   localparam int DEPTH = 2;
   localparam int IN_W  = 48 * LANES;
   localparam int OUT_W = 32 * LANES;

   // FIPS 46-3 S-boxes as printed: [box][row][column].
   localparam int SB [8][4][16] = '{
      '{ '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7},
         '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
         '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0},
         '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13} },
      '{ '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10},
         '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
         '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15},
         '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9} },
      '{ '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8},
         '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
         '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7},
         '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12} },
      '{ '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15},
         '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
         '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4},
         '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14} },
      '{ '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9},
         '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
         '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14},
         '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3} },
      '{ '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
         '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
         '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
         '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13} },
      '{ '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1},
         '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
         '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2},
         '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12} },
      '{ '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7},
         '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
         '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8},
         '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11} }
   };

   localparam int P [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                             2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   errors   = 0;
   int   outs     = 0;
   int   accepts  = 0;
   logic [OUT_W-1:0] q [$];

   des_sbox_pipe_if #(.LANES(LANES)) bus ();

   des_sbox_pipe #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P[i])];
      return y;
   endfunction

   function automatic logic [31:0] ref_lane(input logic [47:0] x);
      logic [31:0] r;
      logic [5:0]  g;
      int          row, col;
      r = '0;
      for (int b = 0; b < 8; b++) begin
         g   = 6'(x >> (42 - 6*b));
         row = 2*int'(g[5]) + int'(g[0]);
         col = int'(g[4:1]);
         r   = {r[27:0], 4'(SB[b][row][col])};
      end
`ifdef DES_SBOX_PERM_EN
      r = ref_perm(r);
`endif
      return r;
   endfunction

   function automatic logic [OUT_W-1:0] ref_beat(input logic [IN_W-1:0] d);
      logic [OUT_W-1:0] o;
      o = '0;
      for (int k = 0; k < LANES; k++) o[32*k +: 32] = ref_lane(d[48*k +: 48]);
      return o;
   endfunction

   function automatic logic [IN_W-1:0] rand_in();
      logic [IN_W-1:0] d;
      d = '0;
      for (int i = 0; i < IN_W/32; i++) d[32*i +: 32] = $urandom();
      return d;
   endfunction

   task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic rdy);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = rdy;
      #1;
   endtask

   // Scoreboard bookkeeping for the cycle about to end, then advance one clock.
   task automatic cycle();
      if (bus.in_valid && bus.in_ready) begin
         q.push_back(ref_beat(bus.in_data));
         accepts++;
      end
      if (bus.out_valid && bus.out_ready) begin
         outs++;
         chk1("sb_pending", q.size() > 0, 1'b1);
         if (q.size() > 0) chk("sb_data", bus.out_data, q.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   // Offer one beat into an empty pipeline and check it appears after DEPTH clocks.
   task automatic lat_beat(input logic [IN_W-1:0] d);
      drive(1'b1, d, 1'b1);
      chk1("lat_in_ready", bus.in_ready, 1'b1);
      cycle();
      for (int i = 1; i < DEPTH; i++) begin
         drive(1'b0, '0, 1'b1);
         chk1("lat_early_out_valid", bus.out_valid, 1'b0);
         chk1("lat_busy", bus.busy, 1'b1);
         cycle();
      end
      drive(1'b0, '0, 1'b1);
      chk1("lat_out_valid", bus.out_valid, 1'b1);
      chk("lat_out_data", bus.out_data, ref_beat(d));
   endtask

   initial begin
      logic [IN_W-1:0]  pend;
      logic [IN_W-1:0]  d;
      logic [47:0]      r48;
      logic [OUT_W-1:0] held;
      logic             acc, v, prev_stall;
      int               n;

      // Reset state, while asserted and directly after release.
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b1);
      @(posedge clk); #1;
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_data", bus.out_data, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk1("post_rst_out_valid", bus.out_valid, 1'b0);
      chk1("post_rst_busy", bus.busy, 1'b0);
      chk1("post_rst_in_ready", bus.in_ready, 1'b1);
      chk("post_rst_out_data", bus.out_data, '0);

      // All-zero input: each lane is row 0 / column 0 of every box.
      lat_beat('0);
`ifndef DES_SBOX_PERM_EN
      chk("zero_lane0_fips", OUT_W'(bus.out_data[31:0]), OUT_W'(32'hEFA72C4D));
`endif
      cycle();
      drive(1'b0, '0, 1'b1);
      chk1("drain_out_valid", bus.out_valid, 1'b0);
      chk1("drain_busy", bus.busy, 1'b0);

      // Single S1 group 011011 -> row 1, column 13.
      lat_beat(IN_W'(48'h6C00_0000_0000));
`ifndef DES_SBOX_PERM_EN
      chk("s1_group_nibble", OUT_W'(bus.out_data[31:28]), OUT_W'(4'h5));
`endif
      cycle();

      // Only lane 2 carries data; the others must look like zero input.
      r48 = {$urandom(), $urandom()} >> 16;
      lat_beat(IN_W'(r48) << 96);
      for (int k = 0; k < LANES; k++)
         chk("lane_isolation", OUT_W'(bus.out_data[32*k +: 32]),
             OUT_W'((k == 2) ? ref_lane(r48) : ref_lane(48'h0)));
      cycle();

      // 16-beat back-to-back burst with the sink always ready.
      n = outs;
      for (int c = 0; c < 16 + DEPTH; c++) begin
         drive(c < 16, rand_in(), 1'b1);
         chk1("burst_in_ready", bus.in_ready, 1'b1);
         chk1("burst_out_valid", bus.out_valid, c >= DEPTH);
         cycle();
      end
      chk("burst_count", OUT_W'(outs - n), OUT_W'(16));

      // Sink stalls with a continuously offered stream until the pipeline is full.
      pend = rand_in();
      held = '0;
      for (int c = 0; c < DEPTH + 5; c++) begin
         drive(1'b1, pend, 1'b0);
         chk1("stall_in_ready", bus.in_ready, c < DEPTH);
         if (c >= DEPTH) chk1("stall_out_valid", bus.out_valid, 1'b1);
         if (c > DEPTH) chk("stall_hold_data", bus.out_data, held);
         held = bus.out_data;
         acc  = bus.in_ready;
         cycle();
         if (acc) pend = rand_in();
      end
      // Release on a full pipeline: accept and drain in the same cycle.
      drive(1'b1, pend, 1'b1);
      chk1("release_in_ready", bus.in_ready, 1'b1);
      chk1("release_out_valid", bus.out_valid, 1'b1);
      cycle();
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, rand_in(), 1'b1);
         cycle();
      end
      for (int c = 0; c <= DEPTH; c++) begin
         drive(1'b0, '0, 1'b1);
         cycle();
      end
      chk("stall_balance", OUT_W'(q.size()), '0);

      // Random valid/ready traffic with bubbles and stalls.
      pend = rand_in();
      prev_stall = 1'b0;
      for (int c = 0; c < 300; c++) begin
         v = ($urandom_range(0, 9) < 7);
         drive(v, pend, $urandom_range(0, 9) < 6);
         if (prev_stall) begin
            chk1("rnd_hold_valid", bus.out_valid, 1'b1);
            chk("rnd_hold_data", bus.out_data, held);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         held = bus.out_data;
         acc  = v && bus.in_ready;
         cycle();
         if (acc) pend = rand_in();
      end
      for (int c = 0; c <= DEPTH; c++) begin
         drive(1'b0, '0, 1'b1);
         cycle();
      end
      chk("rnd_balance", OUT_W'(q.size()), '0);
      chk("rnd_in_out_count", OUT_W'(accepts - outs), '0);

      // Reset asserted mid-burst, away from any clock edge.
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, rand_in(), 1'b1);
         cycle();
      end
      drive(1'b1, rand_in(), 1'b1);
      chk1("pre_rst_out_valid", bus.out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("midrst_out_valid", bus.out_valid, 1'b0);
      chk1("midrst_busy", bus.busy, 1'b0);
      chk1("midrst_in_ready", bus.in_ready, 1'b1);
      chk("midrst_out_data", bus.out_data, '0);
      q.delete();
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      d = rand_in();
      lat_beat(d);
      cycle();
      drive(1'b0, '0, 1'b1);
      cycle();
      chk1("final_busy", bus.busy, 1'b0);
      chk("final_balance", OUT_W'(q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
